// File: rtl/mem_controller_if.sv
// Cache-controller <-> memory handshake: level request in, one-cycle ack strobes out.
interface mem_controller_if #(
    parameter int ADR_WIDTH   = 32,
    parameter int DATA_WIDTH  = 32,
    parameter int WORD_OFFSET = 2
);
    logic                   req_cc2mem;
    logic [ADR_WIDTH-1:0]   adr_cc2mem;
    logic                   we_cc2mem;
    logic [DATA_WIDTH-1:0]  dat_cc2mem;
    logic                   ack_mem2cc;
    logic [DATA_WIDTH-1:0]  dat_mem2cc;
    logic [WORD_OFFSET-1:0] word_mem2cc;

    modport master (
        output req_cc2mem, adr_cc2mem, we_cc2mem, dat_cc2mem,
        input  ack_mem2cc, dat_mem2cc, word_mem2cc
    );

    modport slave (
        input  req_cc2mem, adr_cc2mem, we_cc2mem, dat_cc2mem,
        output ack_mem2cc, dat_mem2cc, word_mem2cc
    );
endinterface

// File: rtl/mem_controller.sv
// Backing-RAM model for a cache: single-word writes and critical-word-first line reads
// with a fixed access latency and one idle cycle between read beats.
module mem_controller #(
    parameter int ADR_WIDTH   = 32,
    parameter int DATA_WIDTH  = 32,
    parameter int WORD_OFFSET = 2,
    parameter int MEM_AW      = 10,
    parameter int LATENCY     = 3
) (
    input logic              clk,
    input logic              rst,
    mem_controller_if.slave  bus
);
    localparam int LINE_W = MEM_AW - WORD_OFFSET;

    typedef enum logic [2:0] {
        S_IDLE, S_WAIT, S_BEAT, S_GAP, S_WRITE, S_RELEASE
    } state_t;

    state_t                 r_state, w_next;
    logic [3:0]             r_cnt;
    logic [WORD_OFFSET-1:0] r_beat;
    logic [WORD_OFFSET-1:0] r_start;
    logic [LINE_W-1:0]      r_line;
    logic                   r_ack;
    logic [DATA_WIDTH-1:0]  r_dout;
    logic [WORD_OFFSET-1:0] r_word;

    logic                   w_ack;
    logic [DATA_WIDTH-1:0]  w_dout;
    logic [WORD_OFFSET-1:0] w_word;
    logic [WORD_OFFSET-1:0] w_rd_word;
    logic                   w_wr_en;

    logic [DATA_WIDTH-1:0]  r_mem [2**MEM_AW];

    assign w_rd_word = r_start + r_beat;
    assign w_wr_en   = rst && (r_state == S_IDLE) && bus.req_cc2mem && bus.we_cc2mem;

    // NOTE: state registers use non-blocking (<=) so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_beat  <= '0;
            r_start <= '0;
            r_line  <= '0;
            r_ack   <= 1'b0;
            r_dout  <= '0;
            r_word  <= '0;
        end else begin
            r_state <= w_next;
            r_ack   <= w_ack;
            r_dout  <= w_dout;
            r_word  <= w_word;
            case (r_state)
                S_IDLE: if (bus.req_cc2mem) begin
                    r_cnt   <= 4'(LATENCY);
                    r_beat  <= '0;
                    r_start <= bus.adr_cc2mem[WORD_OFFSET+1:2];
                    r_line  <= bus.adr_cc2mem[MEM_AW+1:WORD_OFFSET+2];
                end
                S_WAIT, S_WRITE: if (r_cnt != 4'd0) r_cnt <= r_cnt - 4'd1;
                S_BEAT:  r_beat <= r_beat + 1'b1;
                default: ;
            endcase
        end
    end

    // NOTE: RAM has no reset: contents must survive rst, and a reset port would block RAM inference.
    always_ff @(posedge clk) begin
        if (w_wr_en) r_mem[bus.adr_cc2mem[MEM_AW+1:2]] <= bus.dat_cc2mem;
    end

    // NOTE: defaults first in every comb block so no path leaves a variable unassigned (no latches).
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:    if (bus.req_cc2mem) w_next = bus.we_cc2mem ? S_WRITE : S_WAIT;
            S_WAIT:    if (r_cnt <= 4'd1) w_next = S_BEAT;
            S_BEAT:    w_next = (r_beat == '1) ? S_RELEASE : S_GAP;
            S_GAP:     w_next = S_BEAT;
            S_WRITE:   if (r_cnt == 4'd0) w_next = S_RELEASE;
            S_RELEASE: if (!bus.req_cc2mem) w_next = S_IDLE;
            default:   w_next = S_IDLE;
        endcase
    end

    // Outputs are decided one cycle ahead and registered, so the BEAT cycle is the RAM read cycle.
    always_comb begin
        w_ack  = 1'b0;
        w_dout = '0;
        w_word = '0;
        case (r_state)
            S_BEAT: begin
                w_ack  = 1'b1;
                w_dout = r_mem[{r_line, w_rd_word}];
                w_word = w_rd_word;
            end
            S_WRITE: if (r_cnt == 4'd0) begin
                w_ack  = 1'b1;
                w_word = r_start;
            end
            default: ;
        endcase
    end

    assign bus.ack_mem2cc  = r_ack;
    assign bus.dat_mem2cc  = r_dout;
    assign bus.word_mem2cc = r_word;
endmodule

// File: tb/tb_mem_controller.sv
// Directed bench for mem_controller: writes, wrapped line reads, timing, aliasing and reset aborts.
module tb_mem_controller;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    logic [31:0] rd_dat  [4];
    logic [1:0]  rd_word [4];
    int          rd_lat  [4];
    int          lat;
    int          acks;

    mem_controller_if #(.ADR_WIDTH(32), .DATA_WIDTH(32), .WORD_OFFSET(2)) bus ();

    mem_controller #(
        .ADR_WIDTH(32), .DATA_WIDTH(32), .WORD_OFFSET(2), .MEM_AW(10), .LATENCY(3)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Cycles from the capture edge to the next ack; 40 means the bound expired.
    task automatic wait_ack(output int cyc);
        cyc = 0;
        do begin
            tick();
            cyc++;
        end while (!bus.ack_mem2cc && cyc < 40);
    endtask

    task automatic do_write(input logic [31:0] a, input logic [31:0] d, output int cyc);
        bus.req_cc2mem = 1'b1;
        bus.we_cc2mem  = 1'b1;
        bus.adr_cc2mem = a;
        bus.dat_cc2mem = d;
        tick();
        wait_ack(cyc);
    endtask

    task automatic release_req();
        bus.req_cc2mem = 1'b0;
        bus.we_cc2mem  = 1'b0;
        tick();
    endtask

    task automatic read_line(input logic [31:0] a, input bit toggle);
        bus.req_cc2mem = 1'b1;
        bus.we_cc2mem  = 1'b0;
        bus.adr_cc2mem = a;
        tick();
        if (toggle) begin
            bus.adr_cc2mem = 32'h0000_0204;
            bus.dat_cc2mem = 32'h1234_5678;
        end
        for (int i = 0; i < 4; i++) begin
            wait_ack(rd_lat[i]);
            rd_dat[i]  = bus.dat_mem2cc;
            rd_word[i] = bus.word_mem2cc;
        end
    endtask

    task automatic count_acks(input int n, output int cnt);
        cnt = 0;
        for (int i = 0; i < n; i++) begin
            tick();
            if (bus.ack_mem2cc) cnt++;
        end
    endtask

    initial begin
        bus.req_cc2mem = 1'b0;
        bus.we_cc2mem  = 1'b0;
        bus.adr_cc2mem = '0;
        bus.dat_cc2mem = '0;

        // Asynchronous reset before any clock edge
        #1 rst = 1'b0;
        #1;
        check("rst_ack",  32'(bus.ack_mem2cc), 32'd0);
        check("rst_dat",  bus.dat_mem2cc, 32'd0);
        check("rst_word", 32'(bus.word_mem2cc), 32'd0);
        tick();
        tick();
        rst = 1'b1;
        tick();

        // Single write: ack LATENCY+1 cycles after capture, word index 2, no data
        do_write(32'h0000_0108, 32'hAAAA_AAAA, lat);
        check("wr_latency", 32'(lat), 32'd4);
        check("wr_word",    32'(bus.word_mem2cc), 32'd2);
        check("wr_dat",     bus.dat_mem2cc, 32'd0);
        count_acks(3, acks);
        check("wr_one_cycle_no_retrigger", 32'(acks), 32'd0);
        release_req();

        // Line read from word 0
        read_line(32'h0000_0100, 1'b0);
        check("rd0_latency", 32'(rd_lat[0]), 32'd4);
        for (int i = 0; i < 4; i++) check($sformatf("rd0_word%0d", i), 32'(rd_word[i]), 32'(i));
        check("rd0_gap", 32'(rd_lat[1]), 32'd2);
        check("rd0_dat2", rd_dat[2], 32'hAAAA_AAAA);
        release_req();

        // Preload line 0x200 and second word of line 0x100
        for (int i = 0; i < 4; i++) begin
            do_write(32'h0000_0200 + 32'(4 * i), 32'h10 + 32'(i), lat);
            release_req();
        end
        do_write(32'h0000_010C, 32'h5555_1234, lat);
        release_req();

        // Critical word first from word 2, then hold req high past completion
        read_line(32'h0000_0208, 1'b0);
        check("cwf_latency", 32'(rd_lat[0]), 32'd4);
        check("cwf_dat0",  rd_dat[0], 32'h12);
        check("cwf_dat1",  rd_dat[1], 32'h13);
        check("cwf_dat2",  rd_dat[2], 32'h10);
        check("cwf_dat3",  rd_dat[3], 32'h11);
        check("cwf_word0", 32'(rd_word[0]), 32'd2);
        check("cwf_word1", 32'(rd_word[1]), 32'd3);
        check("cwf_word2", 32'(rd_word[2]), 32'd0);
        check("cwf_word3", 32'(rd_word[3]), 32'd1);
        check("cwf_gap1",  32'(rd_lat[1]), 32'd2);
        check("cwf_gap2",  32'(rd_lat[2]), 32'd2);
        check("cwf_gap3",  32'(rd_lat[3]), 32'd2);
        count_acks(10, acks);
        check("hold_no_ack", 32'(acks), 32'd0);
        check("idle_dat_zero", bus.dat_mem2cc, 32'd0);
        release_req();

        // Fresh request after req dropped starts a new transaction
        read_line(32'h0000_020C, 1'b0);
        check("new_latency", 32'(rd_lat[0]), 32'd4);
        check("new_word0",   32'(rd_word[0]), 32'd3);
        check("new_dat0",    rd_dat[0], 32'h13);
        release_req();

        // Upper address bits alias; address changes after capture are ignored
        read_line(32'hFFFF_F108, 1'b1);
        check("alias_word0", 32'(rd_word[0]), 32'd2);
        check("alias_dat0",  rd_dat[0], 32'hAAAA_AAAA);
        check("alias_dat1",  rd_dat[1], 32'h5555_1234);
        release_req();

        // Reset during beat 2 of a burst: outputs clear without a clock, no later beats
        bus.req_cc2mem = 1'b1;
        bus.we_cc2mem  = 1'b0;
        bus.adr_cc2mem = 32'h0000_0200;
        tick();
        wait_ack(lat);
        wait_ack(lat);
        check("mid_beat2_ack", 32'(bus.ack_mem2cc), 32'd1);
        #2 rst = 1'b0;
        #1;
        check("mid_rst_ack",  32'(bus.ack_mem2cc), 32'd0);
        check("mid_rst_dat",  bus.dat_mem2cc, 32'd0);
        check("mid_rst_word", 32'(bus.word_mem2cc), 32'd0);
        bus.req_cc2mem = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        count_acks(12, acks);
        check("mid_rst_no_beats", 32'(acks), 32'd0);

        // Reset during a write after its entry edge: data is retained
        bus.req_cc2mem = 1'b1;
        bus.we_cc2mem  = 1'b1;
        bus.adr_cc2mem = 32'h0000_0110;
        bus.dat_cc2mem = 32'hDEAD_BEEF;
        tick();
        tick();
        rst = 1'b0;
        bus.req_cc2mem = 1'b0;
        bus.we_cc2mem  = 1'b0;
        #1;
        check("wr_rst_ack", 32'(bus.ack_mem2cc), 32'd0);
        tick();
        rst = 1'b1;
        count_acks(8, acks);
        check("wr_rst_no_ack", 32'(acks), 32'd0);
        read_line(32'h0000_0110, 1'b0);
        check("wr_rst_retained_word", 32'(rd_word[0]), 32'd0);
        check("wr_rst_retained_dat",  rd_dat[0], 32'hDEAD_BEEF);
        release_req();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/mem_controller.md
MEM_CONTROLLER -- requirements
Module: mem_controller

Interface
REQ-001 SHALL have parameter ADR_WIDTH, default 32, byte address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, word width.
REQ-003 SHALL have parameter WORD_OFFSET, default 2, log2 words per cache line (4-beat line).
REQ-004 SHALL have parameter MEM_AW, default 10, log2 words of backing RAM.
REQ-005 SHALL have parameter LATENCY, default 3, wait cycles from request capture to first beat (legal range 1..15).
REQ-006 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-007 SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-008 SHALL have port req_cc2mem  input  1  level request from the cache controller.
REQ-009 SHALL have port adr_cc2mem  input  ADR_WIDTH  byte address of the request.
REQ-010 SHALL have port we_cc2mem  input  1  1 = single-word write, 0 = line read.
REQ-011 SHALL have port dat_cc2mem  input  DATA_WIDTH  write data.
REQ-012 SHALL have port ack_mem2cc  output  1  one-cycle beat/completion strobe.
REQ-013 SHALL have port dat_mem2cc  output  DATA_WIDTH  read beat data, valid only while ack_mem2cc=1.
REQ-014 SHALL have port word_mem2cc  output  WORD_OFFSET  word index within the line of the current beat.

Function
REQ-015 SHALL address RAM as word = adr[MEM_AW+1:2]; bits [1:0] ignored; upper bits above MEM_AW+1 ignored (aliasing).
REQ-016 SHALL implement states IDLE, WAIT, BEAT, GAP, WRITE, RELEASE.
REQ-017 IDLE: on req_cc2mem=1, SHALL capture adr, we, dat into registers, load latency counter with LATENCY, go WRITE if we=1 else WAIT.
REQ-018 WAIT: SHALL decrement counter each cycle; on counter reaching 1 go BEAT (first ack exactly LATENCY+1 cycles after the capture edge).
REQ-019 BEAT: SHALL drive ack_mem2cc=1 for exactly one cycle with dat_mem2cc = RAM[line base + beat word] and word_mem2cc = beat word.
REQ-020 Burst order SHALL be critical-word-first with wrap: first word = captured adr[WORD_OFFSET+1:2], subsequent words +1 modulo 2^WORD_OFFSET (e.g. start 2 -> 2,3,0,1).
REQ-021 GAP: SHALL hold ack_mem2cc=0 for exactly one cycle between beats, then BEAT; after the 2^WORD_OFFSET-th beat go RELEASE instead.
REQ-022 WRITE: SHALL write captured dat to RAM[captured word] on entry edge, and after LATENCY cycles pulse ack_mem2cc for one cycle (dat_mem2cc=0, word_mem2cc=captured word), then go RELEASE.
REQ-023 RELEASE: SHALL stay until req_cc2mem=0, then go IDLE; a request held high after completion SHALL NOT retrigger.
REQ-024 Changes of adr/we/dat or drop of req_cc2mem during WAIT/BEAT/GAP/WRITE SHALL be ignored; transaction completes with captured values.
REQ-025 Outside BEAT and write completion, ack_mem2cc SHALL be 0 and dat_mem2cc SHALL be 0.
REQ-026 Read beats SHALL reflect RAM contents at beat time, including any write completed earlier.
REQ-027 Only one transaction SHALL be in flight; no queuing.

Reset
REQ-028 On rst=0 (asynchronous), state SHALL go IDLE and ack_mem2cc=0, dat_mem2cc=0, word_mem2cc=0, counter/beat registers=0, immediately without clock.
REQ-029 Reset mid-burst or mid-write SHALL abort the transaction with no further beats; RAM contents SHALL NOT be cleared by reset (a write whose entry edge already occurred is retained).
REQ-030 After rst returns to 1, first capture SHALL occur on the first rising edge with req_cc2mem=1.

Verification
REQ-031 Write then read: write 0xAAAAAAAA to adr 0x0000_0108 -> ack 1 cycle at LATENCY+1 cycles; read adr 0x0000_0100 -> beats words 0,1,2,3 with word 2 = 0xAAAAAAAA.
REQ-032 Critical word first: preload line 0x200..0x20C with 0x10,0x11,0x12,0x13, read adr 0x0000_0208 -> dat sequence 0x12,0x13,0x10,0x11, word_mem2cc 2,3,0,1, ack pattern 1,0,1,0,1,0,1.
REQ-033 Timing: LATENCY=3, req captured at edge N -> acks at N+4, N+6, N+8, N+10; no ack while req held to N+20; req low then high -> new transaction.
REQ-034 Reset mid-burst: assert rst=0 between beats 2 and 3 -> ack and dat go 0 asynchronously, no further beats after release.
REQ-035 Aliasing/ignored inputs: read adr 0xFFFF_F108 returns same data as 0x0000_0108 (MEM_AW=10); toggling adr during WAIT does not change returned data.
